timing_oracle_responder: RTL

Responder end of the CM/CLK_inter guess protocol: an on-FPGA stand-in for the MCU code checker. It generates the interconnect clock, receives framed guesses over the 8-bit bidirectional CM bus, and compares them byte-by-byte against a loaded secret code. It replies YES or NO after a delay proportional to the matching prefix length, which is the timing leak the attacker side measures. It lets the attacker be exercised board-to-board or in simulation without the MCU.

---
 rtl/timing_oracle_responder.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/timing_oracle_responder.sv
// timing_oracle_responder
// Responder end of the CM/CLK_inter guess protocol. It generates the
// interconnect clock, announces itself, receives framed guesses on the
// bidirectional CM bus and replies YES/NO after a delay that grows with the
// length of the matching prefix (the deliberate timing leak).
// Optional feature macro: RESPONDER_CONST_TIME_EN -- when defined, the compare
// delay is fixed at CODE_LEN*DELAY_PER_BYTE cycles (mitigated checker).
module timing_oracle_responder #(
    parameter int CODE_LEN       = 32,
    parameter int CLK_DIV        = 4,
    parameter int DELAY_PER_BYTE = 256
) (
    input  logic                          CLK_50,
    input  logic                          RST_N,
    output logic                          CLK_inter,
    inout  wire  [7:0]                    CM,
    input  logic                          secret_wr,
    input  logic [$clog2(CODE_LEN)-1:0]   secret_idx,
    input  logic [7:0]                    secret_data,
    output logic                          result_valid,
    output logic                          result_yes,
    output logic [$clog2(CODE_LEN):0]     match_len
);

    localparam int IDX_W = $clog2(CODE_LEN);
    localparam int ML_W  = $clog2(CODE_LEN) + 1;
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(CODE_LEN * DELAY_PER_BYTE + 1);

    localparam logic [7:0] BYTE_START = 8'h01;
    localparam logic [7:0] BYTE_BEGIN = 8'h02;
    localparam logic [7:0] BYTE_YES   = 8'h03;
    localparam logic [7:0] BYTE_NO    = 8'h04;
    localparam logic [7:0] BYTE_END   = 8'h05;
    localparam logic [7:0] BYTE_IDLE  = 8'h06;

    localparam logic [2:0] S_ANNOUNCE   = 3'd0;
    localparam logic [2:0] S_WAIT_START = 3'd1;
    localparam logic [2:0] S_RECV       = 3'd2;
    localparam logic [2:0] S_WAIT_END   = 3'd3;
    localparam logic [2:0] S_COMPARE    = 3'd4;
    localparam logic [2:0] S_REPLY      = 3'd5;

    logic [DIV_W-1:0] div_q;
    logic             clk_q;
    logic             term_s;
    logic             rise_s;
    logic             fall_s;

    logic [2:0]       state_q;
    logic             oe_q;
    logic [7:0]       tx_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ML_W-1:0]  m_q;
    logic             valid_q;
    logic             yes_q;
    logic [ML_W-1:0]  ml_q;

    logic [7:0]       secret_q [CODE_LEN];
    logic [7:0]       guess_q  [CODE_LEN];

    logic [ML_W-1:0]  prefix_len_s;
    logic             prefix_run_s;
    logic [CNT_W-1:0] delay_s;

    assign term_s = (div_q == DIV_W'(CLK_DIV - 1));
    assign rise_s = term_s & ~clk_q;
    assign fall_s = term_s & clk_q;

    assign CM           = oe_q ? tx_q : 8'hzz;
    assign CLK_inter    = clk_q;
    assign result_valid = valid_q;
    assign result_yes   = yes_q;
    assign match_len    = ml_q;

    // Interconnect clock divider: toggle CLK_inter at each terminal count.
    always_ff @(posedge CLK_50) begin
        if (!RST_N) begin
            div_q <= '0;
            clk_q <= 1'b0;
        end else if (term_s) begin
            div_q <= '0;
            clk_q <= ~clk_q;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Secret storage: writable in any state; reads in the same cycle see the old byte.
    always_ff @(posedge CLK_50) begin
        if (!RST_N) begin
            for (int i = 0; i < CODE_LEN; i++) begin
                secret_q[i] <= BYTE_IDLE;
            end
        end else if (secret_wr) begin
            secret_q[secret_idx] <= secret_data;
        end
    end

    // Leading-match length of the stored guess against the secret.
    always_comb begin
        prefix_len_s = '0;
        prefix_run_s = 1'b1;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (prefix_run_s && (guess_q[i] == secret_q[i])) begin
                prefix_len_s = prefix_len_s + ML_W'(1);
            end else begin
                prefix_run_s = 1'b0;
            end
        end
    end

    // Compare delay: one DELAY_PER_BYTE slot per byte examined, or fixed when mitigated.
    always_comb begin
`ifdef RESPONDER_CONST_TIME_EN
        delay_s = CNT_W'(CODE_LEN * DELAY_PER_BYTE);
`else
        if (prefix_len_s == ML_W'(CODE_LEN)) begin
            delay_s = CNT_W'(CODE_LEN * DELAY_PER_BYTE);
        end else begin
            delay_s = (CNT_W'(prefix_len_s) + CNT_W'(1)) * CNT_W'(DELAY_PER_BYTE);
        end
`endif
    end

    // Protocol sequencer: announce, receive frame, compare, reply.
    always_ff @(posedge CLK_50) begin
        if (!RST_N) begin
            state_q <= S_ANNOUNCE;
            oe_q    <= 1'b0;
            tx_q    <= 8'h00;
            idx_q   <= '0;
            cnt_q   <= '0;
            m_q     <= '0;
            valid_q <= 1'b0;
            yes_q   <= 1'b0;
            ml_q    <= '0;
            for (int i = 0; i < CODE_LEN; i++) begin
                guess_q[i] <= BYTE_IDLE;
            end
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_ANNOUNCE: begin
                    if (fall_s) begin
                        if (oe_q) begin
                            oe_q    <= 1'b0;
                            state_q <= S_WAIT_START;
                        end else begin
                            oe_q <= 1'b1;
                            tx_q <= BYTE_BEGIN;
                        end
                    end
                end
                S_WAIT_START: begin
                    if (rise_s && (CM == BYTE_START)) begin
                        idx_q   <= '0;
                        state_q <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (rise_s) begin
                        guess_q[idx_q] <= CM;
                        if (idx_q == IDX_W'(CODE_LEN - 1)) begin
                            state_q <= S_WAIT_END;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                S_WAIT_END: begin
                    if (rise_s) begin
                        if (CM == BYTE_END) begin
                            m_q     <= prefix_len_s;
                            cnt_q   <= delay_s - CNT_W'(1);
                            state_q <= S_COMPARE;
                        end else begin
                            state_q <= S_WAIT_START;
                        end
                    end
                end
                S_COMPARE: begin
                    // cnt_q reaches zero exactly when the delay has elapsed since the END sample.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (fall_s) begin
                        oe_q    <= 1'b1;
                        tx_q    <= (m_q == ML_W'(CODE_LEN)) ? BYTE_YES : BYTE_NO;
                        valid_q <= 1'b1;
                        yes_q   <= (m_q == ML_W'(CODE_LEN));
                        ml_q    <= m_q;
                        state_q <= S_REPLY;
                    end
                end
                S_REPLY: begin
                    if (fall_s) begin
                        oe_q    <= 1'b0;
                        state_q <= S_WAIT_START;
                    end
                end
                default: begin
                    oe_q    <= 1'b0;
                    state_q <= S_ANNOUNCE;
                end
            endcase
        end
    end

endmodule
